rv_mdu_iter: RTL and testbench

RV_MDU_ITER -- requirements
Module: rv_mdu_iter

---
 rtl/rv_mdu_pkg.sv | 47 ++++
 rtl/rv_mdu_div_core.sv | 65 ++++++
 rtl/rv_mdu_iter.sv | 250 +++++++++++++++++++++++++
 tb/tb_rv_mdu_iter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rv_mdu_pkg.sv
// Shared definitions for the iterative RISC-V M-extension unit: funct3 op
// encodings, FSM state type and operand-signedness helpers used by both the
// unit and instruction decode.
package rv_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Width of the signedness class {is_div, rs1_signed, rs2_signed}
  localparam int unsigned CLASS_W = 3;

  // RS1 is treated as a signed value for every op except the unsigned ones
  function automatic logic op_a_signed(input logic [2:0] op);
    return !((op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU));
  endfunction

  // RS2 is signed for mul/mulh and the signed divide pair
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Ops that return the upper half of the 2*XLEN result (div keeps rem there)
  function automatic logic op_hi_half(input logic [2:0] op);
    return op[2] ? op[1] : (op[1:0] != 2'b00);
  endfunction

  // Result-sharing class: ops in the same class produce the same full result
  function automatic logic [CLASS_W-1:0] op_class(input logic [2:0] op);
    return {op[2], op_a_signed(op), op_b_signed(op)};
  endfunction

endpackage

// File: rtl/rv_mdu_div_core.sv
// Restoring unsigned divider: one quotient bit per step. Quotient and
// remainder outputs are the values produced by the current step, so the
// caller can register the final result on the same edge that done_o is high.
module rv_mdu_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   trial_s;

  // One restoring step: shift next dividend bit into the remainder, try subtract
  always_comb begin
    rem_d   = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
    quo_d   = {quo_q[XLEN-2:0], 1'b0};
    trial_s = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
    if (!trial_s[XLEN]) begin
      rem_d = trial_s[XLEN-1:0];
      quo_d = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
      quo_d = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign done_o      = step_i && (cnt_q == CNT_LAST);
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

  // Load operands on start, otherwise advance one bit per step
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rem_q <= {XLEN{1'b0}};
      quo_q <= {XLEN{1'b0}};
      dvs_q <= {XLEN{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else if (start_i) begin
      rem_q <= {XLEN{1'b0}};
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
      cnt_q <= {CW{1'b0}};
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

endmodule

// File: rtl/rv_mdu_iter.sv
// Iterative RISC-V multiply/divide unit. Multiplies by shift-add, MUL_STEP
// multiplier bits per cycle; divides with rv_mdu_div_core, one bit per cycle.
// Divide-by-zero and signed overflow complete in one cycle.
// Optional RV_MDU_RESULT_CACHE_EN: remember the last full result so a
// companion op (mulh then mul, div then rem, ...) on the same operands
// completes in one cycle.
module rv_mdu_iter
  import rv_mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned MUL_CYC = XLEN / MUL_STEP;
  localparam int unsigned MCW     = $clog2(MUL_CYC);
  localparam logic [MCW-1:0] MCNT_LAST = MCW'(MUL_CYC - 1);
  localparam logic [MCW-1:0] MCNT_ONE  = MCW'(1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e state_q, state_d;

  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_mag_q;
  logic [2*XLEN-1:0] prod_q;
  logic [MCW-1:0]    cnt_q;
  logic              neg_q;
  logic              rem_neg_q;
  logic [XLEN-1:0]   result_q;

  logic              rs1_neg_s, rs2_neg_s;
  logic [XLEN-1:0]   rs1_mag_s, rs2_mag_s;
  logic              dbz_s, ovf_s, special_s, hit_s, accept_s;
  logic [XLEN-1:0]   special_res_s, cache_sel_s;

  logic [XLEN+MUL_STEP-1:0] partial_s, sum_s;
  logic [2*XLEN-1:0] prod_nxt_s, prod_fix_s;
  logic              mul_last_s;

  logic              div_start_s, div_step_s, div_done_s;
  logic [XLEN-1:0]   div_quo_s, div_rem_s, quo_fix_s, rem_fix_s;

  // Operand decode on the request inputs
  assign rs1_neg_s = op_a_signed(op_i) & rs1_i[XLEN-1];
  assign rs2_neg_s = op_b_signed(op_i) & rs2_i[XLEN-1];
  assign rs1_mag_s = rs1_neg_s ? -rs1_i : rs1_i;
  assign rs2_mag_s = rs2_neg_s ? -rs2_i : rs2_i;
  assign dbz_s     = op_i[2] && (rs2_i == {XLEN{1'b0}});
  assign ovf_s     = op_i[2] && !op_i[0] && (rs1_i == XMIN) && (rs2_i == {XLEN{1'b1}});
  assign special_s = dbz_s || ovf_s;

  // One-cycle results for divide-by-zero and signed overflow
  always_comb begin
    special_res_s = {XLEN{1'b0}};
    if (dbz_s) begin
      special_res_s = op_i[1] ? rs1_i : {XLEN{1'b1}};
    end else begin
      special_res_s = op_i[1] ? {XLEN{1'b0}} : rs1_i;
    end
  end

  // Shift-add step: low MUL_STEP multiplier bits retire into the high half
  assign partial_s  = {{MUL_STEP{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, prod_q[MUL_STEP-1:0]};
  assign sum_s      = {{MUL_STEP{1'b0}}, prod_q[2*XLEN-1:XLEN]} + partial_s;
  assign prod_nxt_s = {sum_s, prod_q[XLEN-1:MUL_STEP]};
  assign prod_fix_s = neg_q ? -prod_nxt_s : prod_nxt_s;
  assign mul_last_s = (cnt_q == MCNT_LAST);

  assign quo_fix_s = neg_q ? -div_quo_s : div_quo_s;
  assign rem_fix_s = rem_neg_q ? -div_rem_s : div_rem_s;

  rv_mdu_div_core #(.XLEN(XLEN)) u_div_core (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (div_start_s),
    .step_i      (div_step_s),
    .dividend_i  (rs1_mag_s),
    .divisor_i   (rs2_mag_s),
    .done_o      (div_done_s),
    .quotient_o  (div_quo_s),
    .remainder_o (div_rem_s)
  );

`ifdef RV_MDU_RESULT_CACHE_EN
  logic                cache_vld_q;
  logic [XLEN-1:0]     cache_rs1_q, cache_rs2_q;
  logic [CLASS_W-1:0]  cache_cls_q;
  logic [2*XLEN-1:0]   cache_data_q;

  assign hit_s = cache_vld_q && (cache_rs1_q == rs1_i) && (cache_rs2_q == rs2_i)
               && (cache_cls_q == op_class(op_i));
  assign cache_sel_s = op_hi_half(op_i) ? cache_data_q[2*XLEN-1:XLEN] : cache_data_q[XLEN-1:0];

  // Track key of the op in flight; mark valid once its full result is known
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cache_vld_q  <= 1'b0;
      cache_rs1_q  <= {XLEN{1'b0}};
      cache_rs2_q  <= {XLEN{1'b0}};
      cache_cls_q  <= {CLASS_W{1'b0}};
      cache_data_q <= {(2*XLEN){1'b0}};
    end else if (flush_i) begin
      cache_vld_q <= 1'b0;
    end else if (accept_s && !hit_s) begin
      cache_vld_q <= 1'b0;
      cache_rs1_q <= rs1_i;
      cache_rs2_q <= rs2_i;
      cache_cls_q <= op_class(op_i);
    end else if ((state_q == ST_MUL) && mul_last_s) begin
      cache_vld_q  <= 1'b1;
      cache_data_q <= prod_fix_s;
    end else if ((state_q == ST_DIV) && div_done_s) begin
      cache_vld_q  <= 1'b1;
      cache_data_q <= {rem_fix_s, quo_fix_s};
    end
  end
`else
  assign hit_s       = 1'b0;
  assign cache_sel_s = {XLEN{1'b0}};
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_d     = state_q;
    accept_s    = 1'b0;
    div_start_s = 1'b0;
    div_step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (in_valid_i) begin
          accept_s = 1'b1;
          if (special_s || hit_s) begin
            state_d = ST_DONE;
          end else if (op_i[2]) begin
            state_d     = ST_DIV;
            div_start_s = 1'b1;
          end else begin
            state_d = ST_MUL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (mul_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_DIV: begin
        div_step_s = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (div_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_DONE: begin
        if (flush_i || out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand capture, multiplier iteration and result register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q      <= 3'd0;
      a_mag_q   <= {XLEN{1'b0}};
      prod_q    <= {(2*XLEN){1'b0}};
      cnt_q     <= {MCW{1'b0}};
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= {XLEN{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            op_q      <= op_i;
            a_mag_q   <= rs1_mag_s;
            prod_q    <= {{XLEN{1'b0}}, rs2_mag_s};
            cnt_q     <= {MCW{1'b0}};
            neg_q     <= rs1_neg_s ^ rs2_neg_s;
            rem_neg_q <= rs1_neg_s;
            if (special_s) begin
              result_q <= special_res_s;
            end else if (hit_s) begin
              result_q <= cache_sel_s;
            end
          end
        end
        ST_MUL: begin
          if (!flush_i) begin
            prod_q <= prod_nxt_s;
            cnt_q  <= cnt_q + MCNT_ONE;
            if (mul_last_s) begin
              result_q <= op_hi_half(op_q) ? prod_fix_s[2*XLEN-1:XLEN]
                                           : prod_fix_s[XLEN-1:0];
            end
          end
        end
        ST_DIV: begin
          if (!flush_i && div_done_s) begin
            result_q <= op_q[1] ? rem_fix_s : quo_fix_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_rv_mdu_iter.sv
// Directed bench for rv_mdu_iter (XLEN=32, MUL_STEP=4). Expected results and
// latencies are hand-computed; the cache test adapts to RV_MDU_RESULT_CACHE_EN.
module tb_rv_mdu_iter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  rv_mdu_iter #(.XLEN(32), .MUL_STEP(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble inputs after accept, measure latency to out_valid
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    check({tag, "_ready"}, in_ready_o, 64'd1);
    op_i = op; rs1_i = a; rs2_i = b; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; op_i = ~op; rs1_i = ~a; rs2_i = ~b;
    lat = 1;
    while (!out_valid_o && lat < 200) begin
      @(posedge clk_i); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, result_o, exp_res);
  endtask

  // Consume the result; unit must be ready again right after
  task automatic pop(input string tag);
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
    check({tag, "_pop_valid"}, out_valid_o, 64'd0);
    check({tag, "_pop_ready"}, in_ready_o, 64'd1);
  endtask

  initial begin
    logic seen;
    logic [31:0] held;
    int exp_cache_lat;
    rst_i = 1'b1; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    op_i = 3'd0; rs1_i = 32'd0; rs2_i = 32'd0;
    #1;
    check("rst_ready", in_ready_o, 64'd1);
    check("rst_valid", out_valid_o, 64'd0);
    check("rst_result", result_o, 64'd0);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Multiply variants
    run_op("mul", 3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 9);
    held = result_o;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check("stall_valid", out_valid_o, 64'd1);
      check("stall_result", result_o, held);
    end
    pop("mul");
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 9); pop("mulhu");
    run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 9); pop("mulh");
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9); pop("mulhsu");

    // Iterative divide
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33); pop("div");
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33); pop("rem");
    run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33); pop("divu");
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33); pop("remu");

    // Divide by zero and signed overflow shortcuts
    run_op("divu0", 3'd5, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1); pop("divu0");
    run_op("remu0", 3'd7, 32'h0000_1234, 32'h0, 32'h0000_1234, 1); pop("remu0");
    run_op("div0", 3'd4, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1); pop("div0");
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); pop("divovf");
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1); pop("removf");

    // Flush at cycle 10 of a divide
    op_i = 3'd5; rs1_i = 32'd1000; rs2_i = 32'd3; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
    end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    check("flush_ready", in_ready_o, 64'd1);
    check("flush_valid", out_valid_o, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      seen = seen | out_valid_o;
    end
    check("flush_no_result", seen, 64'd0);

    // Flush together with a request in IDLE must not accept
    op_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd5; in_valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_ready", in_ready_o, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i); #1;
      seen = seen | out_valid_o;
    end
    check("flush_idle_no_result", seen, 64'd0);

    // Asynchronous reset in the middle of a multiply
    run_op("mul15", 3'd0, 32'd3, 32'd5, 32'd15, 9); pop("mul15");
    op_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    check("arst_ready", in_ready_o, 64'd1);
    check("arst_valid", out_valid_o, 64'd0);
    check("arst_result", result_o, 64'd0);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;
    run_op("mul42", 3'd0, 32'd7, 32'd6, 32'd42, 9); pop("mul42");

    // Result reuse between mulh and mul on the same operands
`ifdef RV_MDU_RESULT_CACHE_EN
    exp_cache_lat = 1;
`else
    exp_cache_lat = 9;
`endif
    run_op("c_mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9); pop("c_mulh");
    run_op("c_mul", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, exp_cache_lat); pop("c_mul");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
